// File: rtl/box_anim_rend.sv
// Bouncing solid/outlined box overlay for a VGA/HDMI pixel stream; position steps once per frame.
// Colour is registered one cycle behind px/py; no backpressure, one pixel is accepted every clock.
module box_anim_rend #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          BOX_W    = 100,
  parameter int          BOX_H    = 100,
  parameter int          INIT_X   = 200,
  parameter int          INIT_Y   = 150,
  parameter int          STEP     = 2,
  parameter int          BORDER   = 4,
  parameter logic [23:0] FG_RGB   = 24'h00FF00,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       video_active,
  input  logic       frame_tick,
  input  logic       move_en,
  input  logic       outline_mode,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [7:0] bounce_cnt,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BOX_H);
  localparam logic [9:0]  X_MAX10 = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  Y_MAX10 = 10'(V_ACTIVE - BOX_H);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [10:0] BW11    = 11'(BOX_W);
  localparam logic [10:0] BH11    = 11'(BOX_H);
  localparam logic [10:0] BRD11   = 11'(BORDER);

  logic [9:0]  r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;  // 1 = moving towards 0
  logic [7:0]  r_bounce_cnt;
  logic [23:0] r_rgb;

  logic [10:0] w_x_ext, w_y_ext, w_x_inc, w_y_inc;
  logic [9:0]  w_nx, w_ny;
  logic        w_ndx, w_ndy, w_bx, w_by;
  logic [10:0] w_px, w_py, w_right, w_bottom;
  logic        w_in_box, w_edge, w_draw;

  always_comb begin
    w_x_ext = {1'b0, r_box_x};
    w_y_ext = {1'b0, r_box_y};
    w_x_inc = w_x_ext + STEP11;
    w_y_inc = w_y_ext + STEP11;
    w_nx    = r_box_x;
    w_ny    = r_box_y;
    w_ndx   = r_dir_x;
    w_ndy   = r_dir_y;
    w_bx    = 1'b0;
    w_by    = 1'b0;
    if (!r_dir_x) begin
      if (w_x_inc > X_MAX) begin
        w_nx = X_MAX10; w_ndx = 1'b1; w_bx = 1'b1;
      end else begin
        w_nx = r_box_x + STEP10;
      end
    end else begin
      if (w_x_ext < STEP11) begin
        w_nx = '0; w_ndx = 1'b0; w_bx = 1'b1;
      end else begin
        w_nx = r_box_x - STEP10;
      end
    end
    if (!r_dir_y) begin
      if (w_y_inc > Y_MAX) begin
        w_ny = Y_MAX10; w_ndy = 1'b1; w_by = 1'b1;
      end else begin
        w_ny = r_box_y + STEP10;
      end
    end else begin
      if (w_y_ext < STEP11) begin
        w_ny = '0; w_ndy = 1'b0; w_by = 1'b1;
      end else begin
        w_ny = r_box_y - STEP10;
      end
    end
  end

  // Right/bottom distances are only meaningful (non-negative) once inside the box.
  always_comb begin
    w_px     = {1'b0, px};
    w_py     = {1'b0, py};
    w_right  = w_x_ext + BW11;
    w_bottom = w_y_ext + BH11;
    w_in_box = (w_px >= w_x_ext) && (w_px < w_right) &&
               (w_py >= w_y_ext) && (w_py < w_bottom);
    w_edge   = w_in_box && (((w_px - w_x_ext) < BRD11) ||
                            ((w_right - 11'd1 - w_px) < BRD11) ||
                            ((w_py - w_y_ext) < BRD11) ||
                            ((w_bottom - 11'd1 - w_py) < BRD11));
    w_draw   = outline_mode ? w_edge : w_in_box;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_box_x      <= 10'(INIT_X);
      r_box_y      <= 10'(INIT_Y);
      r_dir_x      <= 1'b0;
      r_dir_y      <= 1'b0;
      r_bounce_cnt <= '0;
      r_rgb        <= '0;
    end else begin
      if (frame_tick && move_en) begin
        r_box_x <= w_nx;
        r_box_y <= w_ny;
        r_dir_x <= w_ndx;
        r_dir_y <= w_ndy;
        if (w_bx || w_by) r_bounce_cnt <= r_bounce_cnt + 8'd1;
      end
      r_rgb <= !video_active ? 24'h000000 : (w_draw ? FG_RGB : BG_RGB);
    end
  end

  assign box_x      = r_box_x;
  assign box_y      = r_box_y;
  assign bounce_cnt = r_bounce_cnt;
  assign red        = r_rgb[23:16];
  assign green      = r_rgb[15:8];
  assign blue       = r_rgb[7:0];

endmodule

// File: tb/tb_box_anim_rend.sv
// Directed bench: default box plus a square-area instance whose axes hit walls together.
module tb_box_anim_rend;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] px, py;
  logic       video_active, frame_tick, move_en, outline_mode;
  logic [9:0] box_x, box_y, box2_x, box2_y;
  logic [7:0] bounce_cnt, bounce2_cnt;
  logic [7:0] red, green, blue, red2, green2, blue2;

  int checks = 0;
  int failures = 0;
  logic [23:0] q[$];

  // Reference state: instance 1 (limits 540/380) and corner instance 2 (limits 100/100)
  int mx, my, mdx, mdy, mcnt;
  int nx, ny, ndx, ndy, ncnt;

  always #5 clk = ~clk;

  box_anim_rend dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .video_active(video_active),
    .frame_tick(frame_tick), .move_en(move_en), .outline_mode(outline_mode),
    .box_x(box_x), .box_y(box_y), .bounce_cnt(bounce_cnt),
    .red(red), .green(green), .blue(blue)
  );

  box_anim_rend #(.H_ACTIVE(200), .V_ACTIVE(200), .INIT_X(0), .INIT_Y(0)) dut2 (
    .clk(clk), .rst(rst), .px(px), .py(py), .video_active(video_active),
    .frame_tick(frame_tick), .move_en(move_en), .outline_mode(outline_mode),
    .box_x(box2_x), .box_y(box2_y), .bounce_cnt(bounce2_cnt),
    .red(red2), .green(green2), .blue(blue2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int x, input int y, input bit va);
    int dx, dy;
    bit inb, ed;
    dx  = x - mx;
    dy  = y - my;
    inb = (dx >= 0) && (dx < 100) && (dy >= 0) && (dy < 100);
    ed  = inb && ((dx < 4) || (99 - dx < 4) || (dy < 4) || (99 - dy < 4));
    if (!va) return 24'h000000;
    return (outline_mode ? ed : inb) ? 24'h00FF00 : 24'h000000;
  endfunction

  task automatic axis(inout int p, inout int d, input int maxv, inout bit b);
    if (d > 0) begin
      if (p + 2 > maxv) begin p = maxv; d = -1; b = 1; end
      else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; d = 1; b = 1; end
      else p = p - 2;
    end
  endtask

  task automatic model_tick();
    bit b1, b2;
    b1 = 0; b2 = 0;
    axis(mx, mdx, 540, b1); axis(my, mdy, 380, b1);
    if (b1) mcnt = (mcnt + 1) % 256;
    axis(nx, ndx, 100, b2); axis(ny, ndy, 100, b2);
    if (b2) ncnt = (ncnt + 1) % 256;
  endtask

  task automatic model_reset();
    mx = 200; my = 150; mdx = 1; mdy = 1; mcnt = 0;
    nx = 0;   ny = 0;   ndx = 1; ndy = 1; ncnt = 0;
  endtask

  task automatic chk_box();
    chk("box_x", box_x, mx);
    chk("box_y", box_y, my);
    chk("bounce_cnt", bounce_cnt, mcnt);
    chk("box2_x", box2_x, nx);
    chk("box2_y", box2_y, ny);
    chk("bounce2_cnt", bounce2_cnt, ncnt);
  endtask

  // Expected colour is queued with the pixel it belongs to, popped after the edge that registers it.
  task automatic drive(input int x, input int y, input bit va, input bit tk);
    @(negedge clk);
    px = 10'(x); py = 10'(y); video_active = va; frame_tick = tk;
    q.push_back(exp_rgb(x, y, va));
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("sb_underflow", 1, 0);
    else chk("rgb", {red, green, blue}, q.pop_front());
    if (tk && move_en) model_tick();
    frame_tick = 1'b0;
  endtask

  int tx[12] = '{199, 200, 299, 300, 200, 250, 250, 299, 0, 639, 250, 200};
  int ty[12] = '{150, 150, 249, 249, 149, 250, 249, 150, 0, 479, 200, 250};
  int ox[6]  = '{203, 296, 204, 300, 200, 250};
  int oy[6]  = '{160, 200, 154, 200, 150, 200};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; px = '0; py = '0; video_active = 1'b0; frame_tick = 1'b0;
    move_en = 1'b0; outline_mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {red, green, blue}, 0);
    chk_box();
    @(negedge clk);
    rst = 1'b0;

    // Filled box spot checks and one row swept across both vertical edges
    for (int i = 0; i < 12; i++) drive(tx[i], ty[i], 1, 0);
    for (int x = 195; x <= 305; x++) drive(x, 200, 1, 0);
    drive(250, 200, 0, 0);

    // Tick with move_en low must not move
    drive(250, 200, 1, 1);
    chk_box();

    // Outline mode
    outline_mode = 1'b1;
    for (int i = 0; i < 6; i++) drive(ox[i], oy[i], 1, 0);
    outline_mode = 1'b0;

    // Tick on an active pixel: that pixel uses the pre-move position
    move_en = 1'b1;
    drive(200, 150, 1, 1);
    for (int t = 2; t <= 10; t++) drive(0, 0, 0, 1);
    chk("t10_box_x", box_x, 220);
    chk("t10_box_y", box_y, 170);
    chk("t10_bounce", bounce_cnt, 0);
    drive(219, 200, 1, 0);
    drive(220, 170, 1, 0);

    for (int t = 11; t <= 172; t++) begin
      drive(0, 0, 0, 1);
      chk_box();
      if (t == 51)  chk("corner_cnt_51", bounce2_cnt, 1);
      if (t == 102) begin
        chk("corner_x_102", box2_x, 0);
        chk("corner_y_102", box2_y, 0);
        chk("corner_cnt_102", bounce2_cnt, 2);
      end
      if (t == 116) begin
        chk("ybounce_y", box_y, 380);
        chk("ybounce_cnt", bounce_cnt, 1);
      end
      if (t == 171) begin
        chk("xbounce_x", box_x, 540);
        chk("xbounce_cnt", bounce_cnt, 2);
      end
      if (t == 172) chk("xback_x", box_x, 538);
    end

    // Reset asserted mid-line while the box is lit: outputs clear without a clock edge
    drive(mx + 10, my + 10, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rgb", {red, green, blue}, 0);
    chk_box();
    @(negedge clk);
    rst = 1'b0;
    drive(250, 200, 0, 0);
    drive(250, 200, 1, 0);
    drive(100, 100, 1, 0);

    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
